// File: rtl/es_ctrl_pkg.sv
// Shared definitions for the expression-stack command sequencer.
// Holds the sequencer state encoding, the high-level command opcodes,
// the stack-operation codes driven on ESOp and the push source selects
// driven on pushSrc. No ports; imported by the sequencer files.
package es_ctrl_pkg;

  // Sequencer states. EXEC1 is shared by every single-step command.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EXEC1     = 3'd1,
    LD_WAIT   = 3'd2,
    LD_POP    = 3'd3,
    LD_PUSH   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_WR     = 3'd6,
    ERR       = 3'd7
  } state_e;

  // Command opcodes on cmd_op; 5..7 are illegal.
  typedef enum logic [2:0] {
    OP_PUSHI   = 3'd0,
    OP_LOAD    = 3'd1,
    OP_POPREG  = 3'd2,
    OP_STORE   = 3'd3,
    OP_PUSHREG = 3'd4
  } cmd_op_e;

  typedef enum logic [1:0] {
    ES_PUSH = 2'd0,
    ES_POP  = 2'd1
  } es_op_e;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_IMM = 2'd1,
    SRC_MEM = 2'd2
  } push_src_e;

  // First state entered after accepting a command with the given opcode.
  function automatic state_e first_state(input logic [2:0] op);
    case (op)
      OP_PUSHI, OP_PUSHREG, OP_POPREG: first_state = EXEC1;
      OP_LOAD:                         first_state = LD_WAIT;
      OP_STORE:                        first_state = ST_SETTLE;
      default:                         first_state = ERR;
    endcase
  endfunction

endpackage

// File: rtl/es_cmd_sequencer_if.sv
// Command handshake between instruction decode and the sequencer.
// master: decode side, offers cmd_valid/cmd_op/cmd_imm/cmd_reg.
// slave : sequencer side, returns cmd_ready when idle.
interface es_cmd_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_imm;
  logic [REG_AW-1:0] cmd_reg;

  modport master (output cmd_valid, cmd_op, cmd_imm, cmd_reg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_imm, cmd_reg, output cmd_ready);
endinterface

// File: rtl/es_step_decode.sv
// Combinational strobe decode for the sequencer.
// Inputs : state (the state being entered), op/reg of the latched command.
// Outputs: datapath strobes es_act/es_op/push_src/pop_num/reg_addr/
//          reg_write/wea plus the done/err pulses. The parent registers them.
module es_step_decode
  import es_ctrl_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  state_e            state,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] reg_idx,
  output logic              es_act,
  output logic [1:0]        es_op,
  output logic [1:0]        push_src,
  output logic              pop_num,
  output logic [REG_AW-1:0] reg_addr,
  output logic              reg_write,
  output logic              wea,
  output logic              done,
  output logic              err
);

  always_comb begin
    es_act    = 1'b0;
    es_op     = ES_PUSH;
    push_src  = SRC_REG;
    pop_num   = 1'b0;
    reg_addr  = '0;
    reg_write = 1'b0;
    wea       = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      EXEC1: begin
        done = 1'b1;
        case (op)
          OP_PUSHI: begin
            es_act   = 1'b1;
            push_src = SRC_IMM;
          end
          OP_PUSHREG: begin
            es_act   = 1'b1;
            reg_addr = reg_idx;
          end
          OP_POPREG: begin
            es_act    = 1'b1;
            es_op     = ES_POP;
            reg_write = 1'b1;
            reg_addr  = reg_idx;
          end
          default: ;
        endcase
      end
      // The pop drops the address while the memory word is already captured,
      // so the following push can place the loaded data on top.
      LD_POP: begin
        es_act   = 1'b1;
        es_op    = ES_POP;
        push_src = SRC_MEM;
      end
      LD_PUSH: begin
        es_act   = 1'b1;
        push_src = SRC_MEM;
        done     = 1'b1;
      end
      // Address (TOS) and data (NOS) are both consumed by the write.
      ST_WR: begin
        es_act  = 1'b1;
        es_op   = ES_POP;
        pop_num = 1'b1;
        wea     = 1'b1;
        done    = 1'b1;
      end
      ERR: begin
        err  = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/es_cmd_sequencer.sv
// Expression-stack command sequencer.
// Accepts one stack command over the cmd interface (slave side) and expands
// it into registered ESAct/ESOp/pushSrc/popNum/regAddress/regWrite/wea
// strobes for the stack, register file and data memory, plus done/err.
// Ports: clk, reset (async, active-low), cmd (es_cmd_sequencer_if.slave),
//        datapath strobes, push_in (last PUSHI immediate), done, err.
module es_cmd_sequencer
  import es_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  es_cmd_sequencer_if.slave cmd,
  output logic              ESAct,
  output logic [1:0]        ESOp,
  output logic [1:0]        pushSrc,
  output logic              popNum,
  output logic [DATA_W-1:0] push_in,
  output logic [REG_AW-1:0] regAddress,
  output logic              regWrite,
  output logic              wea,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] push_in_q, push_in_d;

  logic              es_act_q, es_act_d;
  logic [1:0]        es_op_q, es_op_d;
  logic [1:0]        push_src_q, push_src_d;
  logic              pop_num_q, pop_num_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic              reg_write_q, reg_write_d;
  logic              wea_q, wea_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign cmd.cmd_ready = (state_q == IDLE);

  // Next-state and command latch. Command inputs are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    reg_d     = reg_q;
    push_in_d = push_in_q;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          reg_d   = cmd.cmd_reg;
          state_d = first_state(cmd.cmd_op);
          if (cmd.cmd_op == OP_PUSHI) push_in_d = cmd.cmd_imm;
        end
      end
      LD_WAIT:   state_d = LD_POP;
      LD_POP:    state_d = LD_PUSH;
      ST_SETTLE: state_d = ST_WR;
      default:   state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so that they are
  // registered yet line up with that state.
  es_step_decode #(.REG_AW(REG_AW)) u_decode (
    .state     (state_d),
    .op        (op_d),
    .reg_idx   (reg_d),
    .es_act    (es_act_d),
    .es_op     (es_op_d),
    .push_src  (push_src_d),
    .pop_num   (pop_num_d),
    .reg_addr  (reg_addr_d),
    .reg_write (reg_write_d),
    .wea       (wea_d),
    .done      (done_d),
    .err       (err_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      reg_q       <= '0;
      push_in_q   <= '0;
      es_act_q    <= 1'b0;
      es_op_q     <= '0;
      push_src_q  <= '0;
      pop_num_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_write_q <= 1'b0;
      wea_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      push_in_q   <= push_in_d;
      es_act_q    <= es_act_d;
      es_op_q     <= es_op_d;
      push_src_q  <= push_src_d;
      pop_num_q   <= pop_num_d;
      reg_addr_q  <= reg_addr_d;
      reg_write_q <= reg_write_d;
      wea_q       <= wea_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ESAct      = es_act_q;
  assign ESOp       = es_op_q;
  assign pushSrc    = push_src_q;
  assign popNum     = pop_num_q;
  assign push_in    = push_in_q;
  assign regAddress = reg_addr_q;
  assign regWrite   = reg_write_q;
  assign wea        = wea_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_es_cmd_sequencer.sv
// Self-checking bench for es_cmd_sequencer: per-cycle expected strobe
// vectors are queued when a command is driven and compared while the
// sequencer is busy; a small stack/regfile/memory model follows the strobes.
module tb_es_cmd_sequencer;

  typedef struct packed {
    logic        es_act;
    logic [1:0]  es_op;
    logic [1:0]  push_src;
    logic        pop_num;
    logic [1:0]  reg_addr;
    logic        reg_write;
    logic        wea;
    logic        done;
    logic        err;
    logic [15:0] push_in;
  } step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ESAct;
  logic [1:0]  ESOp;
  logic [1:0]  pushSrc;
  logic        popNum;
  logic [15:0] push_in;
  logic [1:0]  regAddress;
  logic        regWrite;
  logic        wea;
  logic        done;
  logic        err;

  int    n_compared = 0;
  int    n_mismatched = 0;
  step_t sb[$];
  logic  [15:0] last_imm = 16'd0;
  bit    mon_en = 1'b0;
  bit    prev_done = 1'b0;

  // Datapath model state
  logic [15:0] stk [0:15];
  int          sp = 0;
  logic [15:0] mem [0:255];
  logic [15:0] regs [0:3];
  logic [15:0] mem_dout = 16'd0;

  es_cmd_sequencer_if #(.DATA_W(16), .REG_AW(2)) cmd_if ();

  es_cmd_sequencer #(.DATA_W(16), .REG_AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .ESAct      (ESAct),
    .ESOp       (ESOp),
    .pushSrc    (pushSrc),
    .popNum     (popNum),
    .push_in    (push_in),
    .regAddress (regAddress),
    .regWrite   (regWrite),
    .wea        (wea),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic step_t mk(input logic a, input logic [1:0] o, input logic [1:0] s, input logic p,
                               input logic [1:0] r, input logic rw, input logic w, input logic d,
                               input logic e, input logic [15:0] imm);
    step_t t;
    t = '{a, o, s, p, r, rw, w, d, e, imm};
    return t;
  endfunction

  function automatic step_t sample_dut();
    step_t t;
    t = '{ESAct, ESOp, pushSrc, popNum, regAddress, regWrite, wea, done, err, push_in};
    return t;
  endfunction

  // Queue the expected per-cycle strobes of one command.
  task automatic push_expected(input logic [2:0] op, input logic [15:0] imm, input logic [1:0] r);
    case (op)
      3'd0: begin
        last_imm = imm;
        sb.push_back(mk(1, 2'd0, 2'd1, 0, 2'd0, 0, 0, 1, 0, last_imm));
      end
      3'd1: begin
        sb.push_back(mk(0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, last_imm));
        sb.push_back(mk(1, 2'd1, 2'd2, 0, 2'd0, 0, 0, 0, 0, last_imm));
        sb.push_back(mk(1, 2'd0, 2'd2, 0, 2'd0, 0, 0, 1, 0, last_imm));
      end
      3'd2: sb.push_back(mk(1, 2'd1, 2'd0, 0, r, 1, 0, 1, 0, last_imm));
      3'd3: begin
        sb.push_back(mk(0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, last_imm));
        sb.push_back(mk(1, 2'd1, 2'd0, 1, 2'd0, 0, 1, 1, 0, last_imm));
      end
      3'd4: sb.push_back(mk(1, 2'd0, 2'd0, 0, r, 0, 0, 1, 0, last_imm));
      default: sb.push_back(mk(0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 1, 1, last_imm));
    endcase
  endtask

  // Wait (bounded) for cmd_ready at a falling edge; returns 1 when ready.
  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_if.cmd_ready;
    if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // Offer one command for a single accept edge, then scramble the inputs.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] imm, input logic [1:0] r);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      #1;
      push_expected(op, imm, r);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_imm   = imm;
      cmd_if.cmd_reg   = r;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 3'($urandom_range(0, 7));
      cmd_if.cmd_imm   = 16'($urandom);
      cmd_if.cmd_reg   = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  // Scoreboard monitor: busy cycles consume one expected step each, idle
  // cycles must show no strobes, and every done is followed by an idle cycle.
  always @(negedge clk) begin
    step_t cur, exp_s;
    if (mon_en) begin
      cur = sample_dut();
      if (prev_done) checkOutput("idle_gap", {31'd0, cmd_if.cmd_ready}, 32'd1);
      if (!cmd_if.cmd_ready) begin
        if (sb.size() == 0) checkOutput("unexpected_step", 32'd0, 32'd1);
        else begin
          exp_s = sb.pop_front();
          checkOutput("step", {4'd0, cur}, {4'd0, exp_s});
        end
      end else begin
        checkOutput("idle_strobes", {4'd0, cur}, {4'd0, mk(0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, last_imm)});
      end
      prev_done = cur.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Stack / register file / synchronous-read memory driven by the strobes.
  always @(posedge clk) begin
    logic [15:0] pre_tos, old_dout, val;
    int pn;
    pre_tos  = (sp > 0) ? stk[sp-1] : 16'd0;
    old_dout = mem_dout;
    if (ESAct) begin
      if (ESOp == 2'd0) begin
        case (pushSrc)
          2'd0:    val = regs[regAddress];
          2'd1:    val = push_in;
          default: val = old_dout;
        endcase
        if (sp < 16) begin
          stk[sp] = val;
          sp = sp + 1;
        end
      end else begin
        if (wea && sp >= 2) mem[pre_tos[7:0]] = stk[sp-2];
        if (regWrite && sp >= 1) regs[regAddress] = pre_tos;
        pn = popNum ? 2 : 1;
        sp = (pn > sp) ? 0 : sp - pn;
      end
    end
    mem_dout = mem[pre_tos[7:0]];
  end

  initial begin
    bit ok;
    int depth_before;
    logic [2:0] churn [4];
    churn = '{3'd3, 3'd6, 3'd4, 3'd2};
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    for (int i = 0; i < 4; i++) regs[i] = 16'd0;
    for (int i = 0; i < 16; i++) stk[i] = 16'd0;
    mem[1]     = 16'h00AB;
    mem[8'hAB] = 16'h1234;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_imm   = 16'd0;
    cmd_if.cmd_reg   = 2'd0;

    // Reset held low for five cycles: every output stays cleared.
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_hold", {4'd0, sample_dut()}, 32'd0);
    end
    reset  = 1'b1;
    mon_en = 1'b1;
    #1;
    checkOutput("post_rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    checkOutput("post_rst_strobes", {4'd0, sample_dut()}, 32'd0);

    // PUSHI 1 then LOAD from mem[1]
    applyStimulus(3'd0, 16'h0001, 2'd0);
    wait_drain();
    applyStimulus(3'd1, 16'h0000, 2'd0);
    wait_drain();
    checkOutput("load_tos", {16'd0, stk[sp-1]}, 32'h0000_00AB);
    checkOutput("load_depth", 32'(sp), 32'd1);

    // PUSHI 0xF then POPREG r2
    applyStimulus(3'd0, 16'h000F, 2'd0);
    applyStimulus(3'd2, 16'h0000, 2'd2);
    wait_drain();
    checkOutput("popreg_r2", {16'd0, regs[2]}, 32'h0000_000F);
    checkOutput("popreg_depth", 32'(sp), 32'd1);

    // PUSHI 0xF, PUSHREG r0 (=0), STORE -> mem[0] = 0xF
    applyStimulus(3'd0, 16'h000F, 2'd0);
    applyStimulus(3'd4, 16'h0000, 2'd0);
    wait_drain();
    depth_before = sp;
    applyStimulus(3'd3, 16'h0000, 2'd0);
    wait_drain();
    checkOutput("store_mem0", {16'd0, mem[0]}, 32'h0000_000F);
    checkOutput("store_depth_drop", 32'(depth_before - sp), 32'd2);

    // Illegal opcode
    applyStimulus(3'd6, 16'h0000, 2'd0);
    wait_drain();
    checkOutput("illegal_depth", 32'(sp), 32'd1);

    // LOAD with cmd_valid held high and ops changing while busy; the next
    // command only lands once the sequencer is back in IDLE.
    wait_ready(ok);
    if (ok) begin
      #1;
      push_expected(3'd1, 16'h0000, 2'd0);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 3'd1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (cmd_if.cmd_ready) break;
        cmd_if.cmd_op  = churn[i % 4];
        cmd_if.cmd_imm = 16'($urandom);
      end
      checkOutput("churn_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      #1;
      push_expected(3'd0, 16'h0055, 2'd0);
      cmd_if.cmd_op  = 3'd0;
      cmd_if.cmd_imm = 16'h0055;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
    end
    wait_drain();
    checkOutput("churn_tos", {16'd0, stk[sp-1]}, 32'h0000_0055);
    checkOutput("churn_nos", {16'd0, stk[sp-2]}, 32'h0000_1234);
    checkOutput("churn_depth", 32'(sp), 32'd2);

    // Reset pulsed during LD_POP: strobes clear immediately, no LD_PUSH.
    applyStimulus(3'd1, 16'h0000, 2'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset  = 1'b0;
    mon_en = 1'b0;
    last_imm = 16'd0;
    #1;
    checkOutput("abort_strobes", {4'd0, sample_dut()}, 32'd0);
    checkOutput("abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("abort_depth", 32'(sp), 32'd2);

    // Normal operation resumes after the abort.
    applyStimulus(3'd0, 16'h0077, 2'd0);
    wait_drain();
    checkOutput("resume_tos", {16'd0, stk[sp-1]}, 32'h0000_0077);
    checkOutput("resume_depth", 32'(sp), 32'd3);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    checkOutput("watchdog", 32'd0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
